// File: rtl/disp_scan4.sv
// Four-digit multiplexed display scanner for a common-anode 7-segment display.
// Holds a 16-bit value, commits new values only at frame boundaries, and scans one nibble per slot.
`timescale 1ns/1ps
module disp_scan4 #(
  parameter int DIV   = 50000,
  parameter int BLANK = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] value,
  input  logic        lz_blank,
  output logic [3:0]  dig,
  output logic [3:0]  an,
  output logic        frame_start
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_reg, cnt_next;
  logic [1:0]    idx_reg, idx_next;
  logic [15:0]   shown_reg, shown_next;
  logic [15:0]   pending_reg, pending_next;
  logic          pend_v_reg, pend_v_next;
  logic [3:0]    dig_reg, dig_next;
  logic [3:0]    an_reg, an_next;
  logic          frame_start_reg, frame_start_next;

  logic          slot_end;
  logic          wrap;
  logic [3:0]    upper_zero;
  logic          blanked;

  assign slot_end = (cnt_reg == CW'(DIV - 1));
  assign wrap     = slot_end && (idx_reg == 2'd3);

  // upper_zero[gi]: nibbles gi..3 of the value about to be shown are all zero
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_upper_zero
      assign upper_zero[gi] = (shown_next[15:4*gi] == '0);
    end
  endgenerate

  always_comb begin
    cnt_next         = slot_end ? '0 : cnt_reg + 1'b1;
    idx_next         = slot_end ? idx_reg + 2'd1 : idx_reg;
    shown_next       = shown_reg;
    pending_next     = pending_reg;
    pend_v_next      = pend_v_reg;
    frame_start_next = wrap;

    // A load on the wrap edge goes straight to the display and leaves nothing pending
    if (wrap && load) begin
      shown_next  = value;
      pend_v_next = 1'b0;
    end else if (load) begin
      pending_next = value;
      pend_v_next  = 1'b1;
    end else if (wrap && pend_v_reg) begin
      shown_next  = pending_reg;
      pend_v_next = 1'b0;
    end
  end

  // Outputs are registered from the next-state values so they track cnt/idx without lag
  always_comb begin
    dig_next = shown_next[{idx_next, 2'b00} +: 4];
    blanked  = lz_blank && (idx_next != 2'd0) && upper_zero[idx_next];
    an_next  = 4'hF;
    if ((cnt_next >= CW'(BLANK)) && !blanked) begin
      an_next = ~(4'b0001 << idx_next);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg         <= '0;
      idx_reg         <= 2'd0;
      shown_reg       <= 16'h0000;
      pending_reg     <= 16'h0000;
      pend_v_reg      <= 1'b0;
      dig_reg         <= 4'h0;
      an_reg          <= 4'hF;
      frame_start_reg <= 1'b0;
    end else begin
      cnt_reg         <= cnt_next;
      idx_reg         <= idx_next;
      shown_reg       <= shown_next;
      pending_reg     <= pending_next;
      pend_v_reg      <= pend_v_next;
      dig_reg         <= dig_next;
      an_reg          <= an_next;
      frame_start_reg <= frame_start_next;
    end
  end

  assign dig         = dig_reg;
  assign an          = an_reg;
  assign frame_start = frame_start_reg;

endmodule

// File: doc/disp_scan4.md
# disp_scan4

Four-digit multiplexed display scanner that sits directly upstream of the 7-segment decoder. It holds a 16-bit hexadecimal/BCD value and presents one nibble at a time on `dig`, which drives the decoder input. It also drives the matching active-low anode of a common-anode 4-digit display. Updates are tear-free (committed only at frame boundaries), adjacent digits are separated by a dead-time gap, and leading-zero blanking is optional.

## Interface
- `DIV`, 50000: clock cycles per digit slot. Legal range ≥ 2.
- `BLANK`, 2: dead-time cycles at the start of each slot, during which all anodes are off. Legal range 1 ≤ BLANK < DIV.

- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `load`  in  1  single-cycle strobe; `value` is captured on that edge.
- `value`  in  16  digits to display; [3:0] is the rightmost digit, [15:12] the leftmost.
- `lz_blank`  in  1  when high, suppresses leading zeros.
- `dig`  out  4  nibble for the current slot; feeds the decoder input.
- `an`  out  4  anode enables, active-low; `an[i]` is digit i (0 = rightmost).
- `frame_start`  out  1  one-cycle pulse when the slot index wraps from 3 to 0.

## Operation
- State:
  - prescaler `cnt` (0..DIV-1)
  - slot index `idx` (2 bits)
  - displayed register `shown` (16 bits)
  - `pending` (16 bits) and `pend_v` (1 bit)
- Prescaler: `cnt` increments each cycle. At `cnt == DIV-1` it returns to 0 and `idx` increments modulo 4.
- Load: `load` high sets `pending <= value` and `pend_v <= 1`. A later load before commit overwrites `pending`; the last one wins.
- Commit: happens on the edge where `idx` wraps from 3 to 0.
  - If `load` is high on that same edge, `shown <= value` directly and `pend_v <= 0`.
  - Else if `pend_v` is set, `shown <= pending` and `pend_v <= 0`.
  - Else `shown` is unchanged.
- `dig` = `shown[4*idx+3 : 4*idx]`. It is driven from registers only, with no combinational path from inputs.
- Digit blanking: digit `idx` is blanked when `lz_blank`=1, `idx` ≠ 0, and nibbles `idx` through 3 of `shown` are all zero. Digit 0 is never blanked, so a value of 0 shows "0".
- `an` = 4'b1111 when `cnt < BLANK` or the digit is blanked. Otherwise `an` = ~(1 << `idx`), so exactly one bit is low.
- `lz_blank` is sampled continuously; a change takes effect on the next output update.
- `frame_start` = 1 on the cycle after the wrap edge, i.e. while `idx`=0 and `cnt`=0. This coincides with the first cycle in which the newly committed `shown` is visible.

## Timing
- Reset values:
  - `cnt`=0, `idx`=0, `shown`=16'h0000, `pending`=0, `pend_v`=0
  - `dig`=4'h0, `an`=4'b1111, `frame_start`=0
- `rst` mid-frame: all state returns to reset values on the next edge, and a pending load is discarded. `rst` has priority over `load`.
- Slot period is DIV cycles and frame period is 4·DIV cycles.
- Within each slot the anode is off for cycles 0..BLANK-1 and on for cycles BLANK..DIV-1.
- `dig` changes only at slot boundaries (`cnt` 0), while the anodes are off. A segment glitch is therefore never visible.
- Load-to-display latency: from the load edge to the start of the next frame, at most 4·DIV cycles.
- Outputs are registered; `an`, `dig` and `frame_start` change only on `clk` edges.

## Test plan
Use DIV=8, BLANK=2 throughout.
- Reset: assert `rst` for 3 cycles. Required: `an`=4'b1111, `dig`=0, `frame_start`=0.
  - After release, `an` = 4'b1110 exactly 2 cycles later.
  - `frame_start` pulses every 32 cycles.
- Scan order: load 16'h1234 with `lz_blank`=0. After the next `frame_start`, the slots show:
  - `dig`=4 with `an`=1110
  - `dig`=3 with `an`=1101
  - `dig`=2 with `an`=1011
  - `dig`=1 with `an`=0111
  - Each slot lasts 6 active cycles after 2 all-off cycles.
- Tear-free update: with 16'h1234 shown, load 16'hABCD during slot 2. The rest of the frame still shows 2 and 1; the next frame shows D, C, B, A.
  - Variant: load 16'h5555 then 16'h6666 in the same frame. Only 6666 is ever shown.
- Simultaneous load and wrap: assert `load` with 16'h0F0F on the exact wrap edge (`idx`=3, `cnt`=7). Required: the following frame shows F, 0, F, 0 and `pend_v`=0.
- Leading-zero blanking: load 16'h0040 with `lz_blank`=1.
  - Slots 0 and 1 are lit (`dig` 0 and 4).
  - Slots 2 and 3 keep `an`=1111.
  - Load 16'h0000: only slot 0 is lit, with `dig`=0.
- Reset mid-operation: load 16'h9999, then assert `rst` before the wrap. Required: `shown` stays 0 and the pending value is never displayed.
